fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer.
// Walks IDLE -> REQ -> WAIT -> HOLD, presenting one instruction at a time to
// decode and redirecting on branch. Responses that belong to a redirected
// fetch are dropped through the kill flag.
// Optional build macro FETCH_CTRL_TRAP_EN: misaligned redirect targets go to
// TRAP_VECTOR and raise a one-cycle trap pulse. Without it the low two target
// bits are cleared and trap stays 0.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic [31:0] pc_next,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        trap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] fetch_pc_s;
  logic        kill_r;
  logic        kill_s;
  logic        valid_r;
  logic        valid_s;
  logic        capture_s;
  logic        req_r;
  logic        trap_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] target_s;
  logic        misaligned_s;

`ifdef FETCH_CTRL_TRAP_EN
  assign misaligned_s = (pc_next[1:0] != 2'b00);
  assign target_s     = misaligned_s ? TRAP_VECTOR : pc_next;
`else
  logic unused_s;
  assign misaligned_s = 1'b0;
  assign target_s     = {pc_next[31:2], 2'b00};
  assign unused_s     = ^{pc_next[1:0], TRAP_VECTOR};
`endif

  // Next-state, next fetch pc and kill/valid bookkeeping for the fetch FSM.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    kill_s     = kill_r;
    valid_s    = valid_r;
    capture_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_s = S_REQ;
        if (branch) begin
          fetch_pc_s = target_s;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
      end
      S_REQ: begin
        if (branch) begin
          fetch_pc_s = target_s;
          if (imem_gnt) begin
            // Request already accepted: its response must be dropped.
            kill_s  = 1'b1;
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
        end else if (imem_gnt) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_s = 1'b0;
          if (kill_r || branch) begin
            state_s = S_REQ;
            if (branch) begin
              fetch_pc_s = target_s;
            end else begin
              fetch_pc_s = fetch_pc_r;
            end
          end else begin
            capture_s  = 1'b1;
            valid_s    = 1'b1;
            fetch_pc_s = fetch_pc_r + 32'd4;
            state_s    = S_HOLD;
          end
        end else begin
          state_s = S_WAIT;
          if (branch) begin
            fetch_pc_s = target_s;
            kill_s     = 1'b1;
          end else begin
            kill_s = kill_r;
          end
        end
      end
      S_HOLD: begin
        if (branch) begin
          // Redirect wins over stall: the held instruction is squashed.
          valid_s    = 1'b0;
          fetch_pc_s = target_s;
          state_s    = S_REQ;
        end else if (!stall) begin
          valid_s = 1'b0;
          state_s = S_REQ;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s    = S_IDLE;
        fetch_pc_s = RESET_VECTOR;
        kill_s     = 1'b0;
        valid_s    = 1'b0;
      end
    endcase
  end

  // Control state: FSM, fetch pc, kill flag and registered request/trap/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      fetch_pc_r <= RESET_VECTOR;
      kill_r     <= 1'b0;
      valid_r    <= 1'b0;
      req_r      <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      kill_r     <= kill_s;
      valid_r    <= valid_s;
      req_r      <= (state_s == S_REQ);
      trap_r     <= branch & misaligned_s;
    end
  end

  // Instruction/pc capture when an un-killed response arrives in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= 32'h0000_0000;
    end else if (capture_s) begin
      instr_r <= imem_rdata;
      pc_r    <= fetch_pc_r;
    end else begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign trap        = trap_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. A small memory model latches
// the granted address and returns it XOR a per-test pattern as read data.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic [31:0] pc_next;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        trap;

  logic [31:0] gnt_addr;
  logic [31:0] data_xor;
  int          n_cmp;
  int          n_err;

`ifdef FETCH_CTRL_TRAP_EN
  localparam logic [31:0] EXP_MIS  = 32'h0000_0100;
  localparam logic        EXP_TRAP = 1'b1;
`else
  localparam logic [31:0] EXP_MIS  = 32'h0000_0020;
  localparam logic        EXP_TRAP = 1'b0;
`endif

  fetch_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .branch     (branch),
    .pc_next    (pc_next),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: remember the address accepted by the grant handshake.
  always @(posedge clk) begin
    if (imem_req && imem_gnt) gnt_addr <= imem_addr;
  end
  assign imem_rdata = gnt_addr ^ data_xor;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; branch = 1'b0; stall = 1'b0; pc_next = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    data_xor = 32'h0000_0000;
    do_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0h expected 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h expected 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL reset_trap: got %0h expected 0", trap); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %0h expected 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %0h expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = 32'(4 * k);
      step();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stream_wait_req k=%0d: got %0h expected 0", k, imem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_wait_valid k=%0d: got %0h expected 0", k, instr_valid); end
      step();
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d: got %0h expected 1", k, instr_valid); end
      n_cmp++; if (pc !== exp) begin n_err++; $display("FAIL stream_pc k=%0d: got %h expected %h", k, pc, exp); end
      n_cmp++; if (instr !== exp) begin n_err++; $display("FAIL stream_instr k=%0d: got %h expected %h", k, instr, exp); end
      if (k < 2) begin
        step();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_req_valid k=%0d: got %0h expected 0", k, instr_valid); end
        n_cmp++; if (imem_addr !== exp + 32'd4) begin n_err++; $display("FAIL stream_addr k=%0d: got %h expected %h", k, imem_addr, exp + 32'd4); end
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid i=%0d: got %0h expected 1", i, instr_valid); end
      n_cmp++; if (pc !== 32'h8 || instr !== 32'h8) begin n_err++; $display("FAIL stall_hold i=%0d: got pc %h instr %h expected 00000008", i, pc, instr); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req i=%0d: got %0h expected 0", i, imem_req); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_release_req: got %0h expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL stall_release_addr: got %h expected 0000000c", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %0h expected 0", instr_valid); end
  endtask

  task automatic test_branch_wait();
    data_xor = 32'hA5A5_0000;
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    step(); step(); step(); step();
    imem_rvalid = 1'b0;
    step();
    n_cmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b0) begin n_err++; $display("FAIL bw_wait4: got addr %h req %0h expected 00000004 0", imem_addr, imem_req); end
    branch = 1'b1; pc_next = 32'h20;
    step();
    n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL bw_redirect_addr: got %h expected 00000020", imem_addr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bw_still_wait: got %0h expected 0", imem_req); end
    branch = 1'b0; imem_rvalid = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bw_discard_valid: got %0h expected 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_err++; $display("FAIL bw_rereq: got req %0h addr %h expected 1 00000020", imem_req, imem_addr); end
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bw_valid: got %0h expected 1", instr_valid); end
    n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL bw_pc: got %h expected 00000020", pc); end
    n_cmp++; if (instr !== 32'hA5A5_0020) begin n_err++; $display("FAIL bw_instr: got %h expected a5a50020", instr); end
  endtask

  task automatic test_wrap();
    data_xor = 32'h0000_FFFF;
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    branch = 1'b1; pc_next = 32'hFFFF_FFFC;
    step();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_branch_addr: got %h expected fffffffc", imem_addr); end
    branch = 1'b0;
    step(); step();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got %h expected fffffffc", pc); end
    n_cmp++; if (instr !== 32'hFFFF_0003) begin n_err++; $display("FAIL wrap_instr: got %h expected ffff0003", instr); end
    step();
    n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_next: got addr %h req %0h expected 00000000 1", imem_addr, imem_req); end
  endtask

  task automatic test_misaligned();
    data_xor = 32'h0000_FFFF;
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    step(); step(); step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL mis_hold: got %0h expected 1", instr_valid); end
    stall = 1'b1; branch = 1'b1; pc_next = 32'h22;
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_squash: got %0h expected 0", instr_valid); end
    n_cmp++; if (imem_addr !== EXP_MIS || imem_req !== 1'b1) begin n_err++; $display("FAIL mis_addr: got addr %h req %0h expected %h 1", imem_addr, imem_req, EXP_MIS); end
    n_cmp++; if (trap !== EXP_TRAP) begin n_err++; $display("FAIL mis_trap: got %0h expected %0h", trap, EXP_TRAP); end
    branch = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL mis_trap_pulse: got %0h expected 0", trap); end
    step();
    n_cmp++; if (pc !== EXP_MIS || instr !== (EXP_MIS ^ 32'h0000_FFFF)) begin n_err++; $display("FAIL mis_fetch: got pc %h instr %h expected pc %h", pc, instr, EXP_MIS); end
  endtask

  task automatic test_reset_mid();
    data_xor = 32'h1234_0000;
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    branch = 1'b1; pc_next = 32'h40;
    step();
    branch = 1'b0;
    step(); step();
    n_cmp++; if (pc !== 32'h40 || instr !== 32'h1234_0040) begin n_err++; $display("FAIL rm_pre: got pc %h instr %h expected 00000040 12340040", pc, instr); end
    step();
    imem_rvalid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_async_req: got req %0h addr %h expected 0 00000000", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin n_err++; $display("FAIL rm_async_out: got valid %0h pc %h instr %h expected zeros", instr_valid, pc, instr); end
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    rst_n = 1'b1;
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_first_req: got req %0h addr %h valid %0h expected 1 00000000 0", imem_req, imem_addr, instr_valid); end
    step();
    n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale_ignored: got req %0h valid %0h expected 1 0", imem_req, instr_valid); end
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    step();
    imem_rvalid = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h1234_0000) begin n_err++; $display("FAIL rm_fetch: got valid %0h pc %h instr %h expected 1 00000000 12340000", instr_valid, pc, instr); end
  endtask

  task automatic test_back_to_back();
    data_xor = 32'h0F0F_0000;
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    step();
    branch = 1'b1; pc_next = 32'h80;
    step();
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h80) begin n_err++; $display("FAIL b2b_kill: got req %0h addr %h expected 0 00000080", imem_req, imem_addr); end
    branch = 1'b0; imem_rvalid = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_err++; $display("FAIL b2b_drop: got valid %0h req %0h addr %h expected 0 1 00000080", instr_valid, imem_req, imem_addr); end
    imem_rvalid = 1'b0;
    step();
    imem_rvalid = 1'b1; branch = 1'b1; pc_next = 32'h90;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h90) begin n_err++; $display("FAIL b2b_coincide: got valid %0h req %0h addr %h expected 0 1 00000090", instr_valid, imem_req, imem_addr); end
    branch = 1'b0;
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h90 || instr !== 32'h0F0F_0090) begin n_err++; $display("FAIL b2b_fetch: got valid %0h pc %h instr %h expected 1 00000090 0f0f0090", instr_valid, pc, instr); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_wait();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
